// File: rtl/wb_cmd_sequencer_pkg.sv
// Shared types for the Wishbone command sequencer: opcodes, response status and FSM states.
package wb_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    OpWrite = 2'd0,
    OpRead  = 2'd1,
    OpPoll  = 2'd2,
    OpRsvd  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    StatOk         = 2'd0,
    StatAckTimeout = 2'd1,
    StatPollFail   = 2'd2,
    StatIllegal    = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StWaitAck = 3'd2,
    StPollGap = 3'd3,
    StResp    = 3'd4
  } state_t;

  // Bits needed to hold any value in 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous first-word-fall-through command queue with occupancy count.
module wb_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // Full refuses a push even when a pop happens in the same cycle.
  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/wb_cmd_sequencer.sv
// Queues WRITE/READ/POLL commands and replays them as Wishbone classic cycles,
// returning exactly one in-order response per command.
module wb_cmd_sequencer
  import wb_cmd_sequencer_pkg::*;
#(
  parameter int unsigned WB_ADR_WIDTH   = 37,
  parameter int unsigned WB_DAT_WIDTH   = 64,
  parameter int unsigned WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int unsigned CMD_FIFO_DEPTH = 16,
  parameter int unsigned ACK_TIMEOUT    = 255,
  parameter int unsigned POLL_MAX       = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [1:0]                      s_cmd_op,
  input  logic [WB_ADR_WIDTH-1:0]         s_cmd_adr,
  input  logic [WB_DAT_WIDTH-1:0]         s_cmd_dat,
  input  logic [WB_SEL_WIDTH-1:0]         s_cmd_sel,
  input  logic [WB_DAT_WIDTH-1:0]         s_cmd_mask,
  input  logic                            s_cmd_valid,
  output logic                            s_cmd_ready,
  output logic [WB_ADR_WIDTH-1:0]         m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0]         m_wb_dat_o,
  output logic [WB_SEL_WIDTH-1:0]         m_wb_sel_o,
  output logic                            m_wb_we_o,
  output logic                            m_wb_stb_o,
  input  logic [WB_DAT_WIDTH-1:0]         m_wb_dat_i,
  input  logic                            m_wb_ack_i,
  output logic [WB_DAT_WIDTH-1:0]         m_rsp_dat,
  output logic [1:0]                      m_rsp_status,
  output logic                            m_rsp_valid,
  input  logic                            m_rsp_ready,
  output logic                            busy,
  output logic [$clog2(CMD_FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CmdWidth = 2 + WB_ADR_WIDTH + 2 * WB_DAT_WIDTH + WB_SEL_WIDTH;
  localparam int unsigned TmrWidth = cnt_width(ACK_TIMEOUT);
  localparam int unsigned AttWidth = cnt_width(POLL_MAX);
  localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'(ACK_TIMEOUT - 1);
  localparam logic [AttWidth-1:0] AttLast = AttWidth'(POLL_MAX - 1);

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CmdWidth-1:0]     fifo_wdata, fifo_rdata;
  logic [1:0]              head_op_raw;
  op_t                     head_op;
  logic [WB_ADR_WIDTH-1:0] head_adr;
  logic [WB_DAT_WIDTH-1:0] head_dat, head_mask;
  logic [WB_SEL_WIDTH-1:0] head_sel;

  state_t                  state_q, state_d;
  op_t                     op_q;
  logic [WB_ADR_WIDTH-1:0] adr_q;
  logic [WB_DAT_WIDTH-1:0] dat_q, mask_q;
  logic [WB_SEL_WIDTH-1:0] sel_q;
  logic [TmrWidth-1:0]     tmr_q, tmr_d;
  logic [AttWidth-1:0]     att_q, att_d;
  logic [WB_DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  status_t                 rsp_status_q, rsp_status_d;
  logic                    cmd_rdy_q;

  // Ready is held low through reset and for the edge that releases it.
  assign s_cmd_ready = cmd_rdy_q & ~fifo_full;
  assign fifo_push   = s_cmd_valid & s_cmd_ready;
  assign fifo_pop    = (state_q == StIdle) & ~fifo_empty;
  assign fifo_wdata  = {s_cmd_op, s_cmd_adr, s_cmd_dat, s_cmd_sel, s_cmd_mask};
  assign {head_op_raw, head_adr, head_dat, head_sel, head_mask} = fifo_rdata;
  assign head_op     = op_t'(head_op_raw);

  wb_cmd_fifo #(
    .WIDTH (CmdWidth),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    att_d        = att_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          tmr_d = '0;
          att_d = '0;
          if (head_op == OpRsvd) begin
            rsp_status_d = StatIllegal;
            rsp_dat_d    = '0;
            state_d      = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue, StWaitAck: begin
        if (m_wb_ack_i) begin
          state_d      = StResp;
          rsp_status_d = StatOk;
          rsp_dat_d    = m_wb_dat_i;
          unique case (op_q)
            OpWrite: rsp_dat_d = '0;
            OpRead:  ;
            default: begin
              if (((m_wb_dat_i ^ dat_q) & mask_q) != '0) begin
                if (att_q == AttLast) begin
                  rsp_status_d = StatPollFail;
                end else begin
                  att_d   = att_q + 1'b1;
                  tmr_d   = '0;
                  state_d = StPollGap;
                end
              end
            end
          endcase
        end else if (tmr_q == TmrLast) begin
          rsp_status_d = StatAckTimeout;
          rsp_dat_d    = '0;
          state_d      = StResp;
        end else begin
          tmr_d   = tmr_q + 1'b1;
          state_d = StWaitAck;
        end
      end
      StPollGap: state_d = StIssue;
      StResp: begin
        if (m_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tmr_q        <= '0;
      att_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= StatOk;
      cmd_rdy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      att_q        <= att_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      cmd_rdy_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= OpWrite;
      adr_q  <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      mask_q <= '0;
    end else if (fifo_pop) begin
      op_q   <= head_op;
      adr_q  <= head_adr;
      dat_q  <= head_dat;
      sel_q  <= head_sel;
      mask_q <= head_mask;
    end
  end

  assign m_wb_stb_o   = (state_q == StIssue) || (state_q == StWaitAck);
  assign m_wb_we_o    = m_wb_stb_o && (op_q == OpWrite);
  assign m_wb_adr_o   = adr_q;
  assign m_wb_dat_o   = dat_q;
  assign m_wb_sel_o   = sel_q;
  assign m_rsp_valid  = (state_q == StResp);
  assign m_rsp_dat    = rsp_dat_q;
  assign m_rsp_status = rsp_status_q;
  assign busy         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Scoreboard bench: a reference model predicts bus attempts and responses per command,
// a Wishbone slave process plays the planned attempts and a monitor checks responses.
module tb_wb_cmd_sequencer;

  localparam int unsigned AW = 37, DW = 64, SW = 8, DEPTH = 16, TO = 8, PM = 4;
  localparam logic [7:0] NEVER = 8'hFF;

  typedef struct packed {
    logic [1:0]             op;
    logic [AW-1:0]          adr;
    logic [DW-1:0]          dat;
    logic [SW-1:0]          sel;
    logic [DW-1:0]          mask;
    logic [PM-1:0][7:0]     waits;
    logic [PM-1:0][DW-1:0]  rd;
  } cmd_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          we;
    logic [7:0]    waits;
    logic [DW-1:0] rd;
    logic          retry;
  } att_t;

  typedef struct packed {
    logic [1:0]    status;
    logic [DW-1:0] dat;
  } exp_t;

  logic          clk, reset_n;
  logic [1:0]    s_cmd_op;
  logic [AW-1:0] s_cmd_adr;
  logic [DW-1:0] s_cmd_dat, s_cmd_mask;
  logic [SW-1:0] s_cmd_sel;
  logic          s_cmd_valid, s_cmd_ready;
  logic [AW-1:0] m_wb_adr_o;
  logic [DW-1:0] m_wb_dat_o, m_wb_dat_i;
  logic [SW-1:0] m_wb_sel_o;
  logic          m_wb_we_o, m_wb_stb_o, m_wb_ack_i;
  logic [DW-1:0] m_rsp_dat;
  logic [1:0]    m_rsp_status;
  logic          m_rsp_valid, m_rsp_ready, busy;
  logic [4:0]    fifo_count;

  int   n_vec = 0, n_miss = 0;
  exp_t exp_q[$];
  att_t att_q[$];
  logic rr_mode = 1'b0, rr_force = 1'b1;

  wb_cmd_sequencer #(
    .WB_ADR_WIDTH   (AW),
    .WB_DAT_WIDTH   (DW),
    .WB_SEL_WIDTH   (SW),
    .CMD_FIFO_DEPTH (DEPTH),
    .ACK_TIMEOUT    (TO),
    .POLL_MAX       (PM)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_cmd_op     (s_cmd_op),
    .s_cmd_adr    (s_cmd_adr),
    .s_cmd_dat    (s_cmd_dat),
    .s_cmd_sel    (s_cmd_sel),
    .s_cmd_mask   (s_cmd_mask),
    .s_cmd_valid  (s_cmd_valid),
    .s_cmd_ready  (s_cmd_ready),
    .m_wb_adr_o   (m_wb_adr_o),
    .m_wb_dat_o   (m_wb_dat_o),
    .m_wb_sel_o   (m_wb_sel_o),
    .m_wb_we_o    (m_wb_we_o),
    .m_wb_stb_o   (m_wb_stb_o),
    .m_wb_dat_i   (m_wb_dat_i),
    .m_wb_ack_i   (m_wb_ack_i),
    .m_rsp_dat    (m_rsp_dat),
    .m_rsp_status (m_rsp_status),
    .m_rsp_valid  (m_rsp_valid),
    .m_rsp_ready  (m_rsp_ready),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  // Reference model: walk the planned slave behaviour attempt by attempt.
  task automatic model(input cmd_t c);
    exp_t e;
    att_t a;
    e = '0;
    if (c.op == 2'd3) begin
      e.status = 2'd3;
      exp_q.push_back(e);
      return;
    end
    for (int k = 0; k < PM; k++) begin
      a = '{adr: c.adr, dat: c.dat, sel: c.sel, we: (c.op == 2'd0), waits: c.waits[k],
            rd: c.rd[k], retry: (k > 0)};
      att_q.push_back(a);
      if (c.waits[k] == NEVER) begin
        e = '{status: 2'd1, dat: '0};
        break;
      end
      if (c.op == 2'd0) begin e = '{status: 2'd0, dat: '0}; break; end
      if (c.op == 2'd1) begin e = '{status: 2'd0, dat: c.rd[k]}; break; end
      if ((c.rd[k] & c.mask) == (c.dat & c.mask)) begin
        e = '{status: 2'd0, dat: c.rd[k]};
        break;
      end
      if (k == PM - 1) e = '{status: 2'd2, dat: c.rd[k]};
    end
    exp_q.push_back(e);
  endtask

  function automatic cmd_t mk(input logic [1:0] op, input logic [AW-1:0] adr,
                              input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                              input logic [DW-1:0] mask);
    cmd_t c;
    c = '0;
    c.op = op; c.adr = adr; c.dat = dat; c.sel = sel; c.mask = mask;
    for (int k = 0; k < PM; k++) c.rd[k] = {$urandom(), $urandom()};
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int   r;
    logic [DW-1:0] rnd;
    r = $urandom_range(0, 9);
    c = mk((r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
           AW'({$urandom(), $urandom()}), {$urandom(), $urandom()}, SW'($urandom()),
           {$urandom(), $urandom()} & {$urandom(), $urandom()});
    for (int k = 0; k < PM; k++) begin
      c.waits[k] = ($urandom_range(0, 15) == 0) ? NEVER : 8'($urandom_range(0, 3));
      rnd = {$urandom(), $urandom()};
      c.rd[k] = ($urandom_range(0, 2) == 0) ? ((c.dat & c.mask) | (rnd & ~c.mask)) : rnd;
    end
    return c;
  endfunction

  task automatic push(input cmd_t c, output int stalls);
    int guard;
    guard = 0;
    @(negedge clk);
    s_cmd_op = c.op; s_cmd_adr = c.adr; s_cmd_dat = c.dat; s_cmd_sel = c.sel;
    s_cmd_mask = c.mask; s_cmd_valid = 1'b1;
    while (!s_cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    stalls = guard;
    if (!s_cmd_ready) begin
      flag("push_ready_timeout");
      s_cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(c);
    #1 s_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_rsp_q", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Wishbone slave: serves planned attempts in order and checks the bus side.
  att_t cur;
  logic [AW+DW+SW:0] snap;
  int   cnt, gap;
  logic in_att, acked;
  always @(negedge clk) begin
    if (!reset_n) begin
      in_att = 1'b0; acked = 1'b0; m_wb_ack_i = 1'b0; gap = 0; cnt = 0;
    end else begin
      m_wb_ack_i = 1'b0;
      m_wb_dat_i = {$urandom(), $urandom()};
      if (acked) begin
        check("stb_drop_after_ack", m_wb_stb_o, 0);
        acked = 1'b0; in_att = 1'b0; gap = 0;
      end
      if (m_wb_stb_o) begin
        if (!in_att) begin
          if (att_q.size() == 0) flag("stb_without_cmd");
          else begin
            cur = att_q.pop_front();
            in_att = 1'b1; cnt = 0;
            snap = {m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o};
            check("bus_adr", m_wb_adr_o, cur.adr);
            check("bus_sel", m_wb_sel_o, cur.sel);
            check("bus_we", m_wb_we_o, cur.we);
            if (cur.we) check("bus_wdat", m_wb_dat_o, cur.dat);
            if (cur.retry) check("poll_gap_len", gap, 1);
          end
        end else begin
          check("bus_stable", {m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o}, snap);
        end
        cnt++;
        if (in_att && cur.waits != NEVER && cnt == int'(cur.waits) + 1) begin
          m_wb_ack_i = 1'b1;
          m_wb_dat_i = cur.rd;
          acked = 1'b1;
        end
      end else if (in_att) begin
        check("timeout_stb_len", cnt, TO);
        check("timeout_planned", cur.waits, NEVER);
        in_att = 1'b0; gap = 0;
      end else begin
        gap++;
      end
    end
  end

  // Response side: drive ready, then check any handshake against the scoreboard.
  exp_t e_m;
  logic held;
  logic [DW+1:0] held_pl;
  always @(negedge clk) begin
    m_rsp_ready = rr_mode ? ($urandom_range(0, 3) != 0) : rr_force;
    if (!reset_n) held = 1'b0;
    else if (m_rsp_valid) begin
      if (held) check("rsp_stable", {m_rsp_status, m_rsp_dat}, held_pl);
      if (m_rsp_ready) begin
        if (exp_q.size() == 0) flag("unexpected_rsp");
        else begin
          e_m = exp_q.pop_front();
          check("rsp_status", m_rsp_status, e_m.status);
          check("rsp_dat", m_rsp_dat, e_m.dat);
        end
        held = 1'b0;
      end else begin
        held = 1'b1;
        held_pl = {m_rsp_status, m_rsp_dat};
      end
    end else held = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    int   st, tot, guard;
    reset_n = 1'b0; s_cmd_valid = 1'b0; s_cmd_op = '0; s_cmd_adr = '0; s_cmd_dat = '0;
    s_cmd_sel = '0; s_cmd_mask = '0; m_wb_dat_i = '0; m_wb_ack_i = 1'b0; m_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stb", m_wb_stb_o, 0);
    check("rst_we", m_wb_we_o, 0);
    check("rst_adr", m_wb_adr_o, 0);
    check("rst_ready", s_cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_rsp_valid", m_rsp_valid, 0);
    reset_n = 1'b1;
    #1 check("ready_before_edge", s_cmd_ready, 0);
    @(negedge clk);
    check("ready_after_reset", s_cmd_ready, 1);

    // Zero-wait WRITE: stb two cycles after acceptance, one stb cycle, response next cycle.
    c = mk(2'd0, 37'h10, 64'h1122334455667788, 8'hFF, '0);
    push(c, st);
    @(negedge clk); check("stb_not_yet", m_wb_stb_o, 0);
    @(negedge clk); check("stb_lat2", m_wb_stb_o, 1); check("write_we", m_wb_we_o, 1);
    @(negedge clk); check("stb_one_cycle", m_wb_stb_o, 0); check("rsp_after_ack", m_rsp_valid, 1);
    drain();

    c = mk(2'd1, 37'h20, '0, 8'h0F, '0);
    c.waits[0] = 8'd3; c.rd[0] = 64'hDEADBEEF;
    push(c, st);
    drain();

    c = mk(2'd2, 37'h30, 64'h1, 8'hFF, 64'h1);
    c.rd[0] = 64'h0; c.rd[1] = 64'h0; c.rd[2] = 64'h1;
    push(c, st);
    drain();

    c = mk(2'd2, 37'h38, 64'h5, 8'hFF, 64'hF);
    for (int k = 0; k < PM; k++) c.rd[k] = 64'h0;
    push(c, st);
    c = mk(2'd1, 37'h48, '0, 8'hFF, '0);
    c.waits[0] = NEVER;
    push(c, st);
    drain();

    // Reserved opcode: no bus cycle, response one cycle after the pop.
    c = mk(2'd3, 37'h50, '0, 8'h00, '0);
    push(c, st);
    @(negedge clk); check("illegal_not_yet", m_rsp_valid, 0);
    @(negedge clk); check("illegal_rsp", m_rsp_valid, 1); check("illegal_no_stb", m_wb_stb_o, 0);
    drain();

    // Fill: first command parks in RESP, sixteen more fill the queue.
    rr_force = 1'b0;
    tot = 0;
    for (int i = 0; i < 17; i++) begin
      c = mk(2'd0, AW'(i), {$urandom(), $urandom()}, 8'hFF, '0);
      push(c, st);
      tot += st;
    end
    check("fill_no_stall", tot, 0);
    @(negedge clk);
    check("fill_count", fifo_count, 16);
    check("fill_ready_low", s_cmd_ready, 0);
    check("fill_busy", busy, 1);
    check("fill_rsp_held", m_rsp_valid, 1);
    rr_force = 1'b1;
    drain();

    // Reset in the middle of a bus cycle that would otherwise time out.
    c = mk(2'd1, 37'h60, '0, 8'hFF, '0);
    c.waits[0] = NEVER;
    push(c, st);
    push(mk(2'd0, 37'h68, 64'h1, 8'h01, '0), st);
    push(mk(2'd0, 37'h70, 64'h2, 8'h02, '0), st);
    guard = 0;
    while (!m_wb_stb_o && guard < 50) begin @(negedge clk); guard++; end
    check("pre_reset_stb", m_wb_stb_o, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    att_q.delete();
    #1;
    check("midrst_stb", m_wb_stb_o, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", m_rsp_valid, 0);
    check("midrst_ready", s_cmd_ready, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset2", s_cmd_ready, 1);
    repeat (30) @(negedge clk);
    check("idle_after_reset", busy, 0);

    rr_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      push(rand_cmd(), st);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    rr_mode = 1'b0;
    check("attempts_consumed", att_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
